// File: rtl/cmos_test_pkg.sv
// cmos_test_pkg: shared types and constants for the 2-input cell truth checker.
//   chk_state_t  - checker FSM states
//   vec2_t       - {in1,in2} stimulus vector
//   TRUTH_*      - truth tables for common cells, indexed by {in1,in2}
//   cnt3_inc     - saturation-free 3-bit increment helper (max 4 steps per run)
`timescale 1ns/1ps
package cmos_test_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} chk_state_t;
  typedef logic [1:0] vec2_t;

  localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
  localparam logic [3:0] TRUTH_NOR2  = 4'b0001;
  localparam logic [3:0] TRUTH_AND2  = 4'b1000;

  function automatic logic [2:0] cnt3_inc(input logic [2:0] v, input logic en);
    return v + {2'b00, en};
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: 8-bit loadable down-counter that parks at zero.
//   clk      in  clock
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load load_val this cycle (wins over counting)
//   load_val in  8-bit reload value
//   zero     out count is zero
`timescale 1ns/1ps
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= 8'd0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/gate2_truth_checker.sv
// gate2_truth_checker: steps a 2-input cell through vectors 00,01,10,11, lets
// each settle for SETTLE cycles, samples the cell output and checks it
// against TRUTH[{in1,in2}].
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured only in IDLE)
//   dut_in1/2  out  cell stimulus
//   dut_out    in   cell response (may be x/z)
//   busy       out  run in progress
//   done       out  one-cycle pulse at end of run
//   pass       out  last run had no mismatches
//   err_count  out  mismatching vectors, 0..4
//   fail_vec   out  bit i set: vector i mismatched
//   xz_count   out  x/z samples, 0..4
// Build option: define XZ_CHECK_EN to treat x/z samples as mismatches and
// count them; otherwise dut_out is read as 2-state and xz_count stays 0.
`timescale 1ns/1ps
module gate2_truth_checker
  import cmos_test_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = TRUTH_NAND2,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_in1,
  output logic       dut_in2,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [2:0] xz_count
);

  // Timer reload: counts SETTLE-1 .. 0, so DRIVE lasts SETTLE cycles.
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);

  chk_state_t state_q;
  vec2_t      vec_q;
  vec2_t      vec_inc;
  logic       busy_q, done_q, pass_q, in1_q, in2_q;
  logic [2:0] err_q, err_d, xz_q, xz_d;
  logic [3:0] fail_q;
  logic       exp_bit, mismatch, xz_hit;
  logic       timer_load, timer_zero;

  always_comb begin
    exp_bit = TRUTH[vec_q];
`ifdef XZ_CHECK_EN
    xz_hit   = $isunknown(dut_out);
    mismatch = xz_hit || (dut_out !== exp_bit);
`else
    // 2-state cast: x/z collapse to 0 before the compare.
    xz_hit   = 1'b0;
    mismatch = (bit'(dut_out) != bit'(exp_bit));
`endif
    err_d   = cnt3_inc(err_q, mismatch);
    xz_d    = cnt3_inc(xz_q, xz_hit);
    vec_inc = vec_q + 2'd1;
  end

  // Reload on every entry into DRIVE.
  assign timer_load = ((state_q == IDLE) && start) ||
                      ((state_q == SAMPLE) && (vec_q != 2'd3));

  settle_timer u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      xz_q    <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= 2'd0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            xz_q    <= 3'd0;
            fail_q  <= 4'd0;
          end
        end
        DRIVE: begin
          if (timer_zero) state_q <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_q[vec_q] <= 1'b1;
            err_q         <= err_d;
          end
          xz_q <= xz_d;
          if (vec_q == 2'd3) begin
            // pass uses the count including this last sample.
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_inc;
            in1_q   <= vec_inc[1];
            in2_q   <= vec_inc[0];
          end
        end
        FIN: begin
          // start here is dropped, not queued.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in1   = in1_q;
  assign dut_in2   = in2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign xz_count  = xz_q;

endmodule

// File: tb/tb_gate2_truth_checker.sv
// Bench for gate2_truth_checker: instance A (NAND2 table) sees a switchable
// cell model (NAND2 / stuck-at-1 / floating), instance B (NOR2 table) always
// sees a NAND2 cell. Expected values are hand-derived constants.
`timescale 1ns/1ps
module tb_gate2_truth_checker;
  import cmos_test_pkg::*;

  logic clk = 1'b0;
  logic rst, start_a, start_b;
  always #5 clk = ~clk;

  logic       a_in1, a_in2, a_busy, a_done, a_pass, a_cell;
  logic [2:0] a_err, a_xz;
  logic [3:0] a_fail;
  wire        a_out;
  logic       b_in1, b_in2, b_out, b_busy, b_done, b_pass;
  logic [2:0] b_err, b_xz;
  logic [3:0] b_fail;

  int cell_mode;   // 0: NAND2, 1: stuck-at-1, 2: floating
  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    a_cell = ~(a_in1 & a_in2);
    if (cell_mode == 1) a_cell = 1'b1;
  end
  assign a_out = (cell_mode == 2) ? 1'bz : a_cell;
  always_comb b_out = ~(b_in1 & b_in2);

  gate2_truth_checker #(.TRUTH(TRUTH_NAND2), .SETTLE(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in1(a_in1), .dut_in2(a_in2),
    .dut_out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .fail_vec(a_fail), .xz_count(a_xz));

  gate2_truth_checker #(.TRUTH(TRUTH_NOR2), .SETTLE(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in1(b_in1), .dut_in2(b_in2),
    .dut_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .fail_vec(b_fail), .xz_count(b_xz));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start_a and return the cycle (relative to the accepting edge) in
  // which done was seen, or 0 if it never came.
  task automatic run_a(output int lat);
    start_a = 1'b1; tick(); start_a = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (a_done) begin lat = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cell_mode = 0;
    repeat (3) tick();
    n_cmp++;
    if ({a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail, a_xz} !== 16'd0) begin
      $display("FAIL reset_a: got %b want all zero",
               {a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail, a_xz}); n_bad++;
    end
    n_cmp++;
    if ({b_in1, b_in2, b_busy, b_done, b_pass, b_err, b_fail, b_xz} !== 16'd0) begin
      $display("FAIL reset_b: got %b want all zero",
               {b_in1, b_in2, b_busy, b_done, b_pass, b_err, b_fail, b_xz}); n_bad++;
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_nand_pass();
    int lat;
    logic [1:0] ev;
    cell_mode = 0; repeat (2) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (a_done) begin lat = c; break; end
      if (c <= 12) begin
        ev = 2'((c - 1) / 3);
        n_cmp++;
        if ({a_in1, a_in2, a_busy} !== {ev, 1'b1}) begin
          $display("FAIL nand_drive c=%0d: in/busy %b want %b", c, {a_in1, a_in2, a_busy}, {ev, 1'b1});
          n_bad++;
        end
      end
      tick();
    end
    n_cmp++;
    if (lat !== 13) begin $display("FAIL nand_latency: got %0d want 13", lat); n_bad++; end
    n_cmp++;
    if ({a_pass, a_err, a_fail, a_busy, a_in1, a_in2} !== {1'b1, 3'd0, 4'b0000, 3'b000}) begin
      $display("FAIL nand_result: pass=%b err=%0d fail=%b busy=%b in=%b%b want 1 0 0000 0 00",
               a_pass, a_err, a_fail, a_busy, a_in1, a_in2); n_bad++;
    end
    tick(); n_cmp++;
    if (a_done !== 1'b0 || a_pass !== 1'b1) begin
      $display("FAIL nand_after: done=%b pass=%b want 0 1", a_done, a_pass); n_bad++;
    end
  endtask

  task automatic test_stuck_at1();
    int lat;
    cell_mode = 1; repeat (2) tick();
    run_a(lat);
    n_cmp++;
    if (lat !== 13) begin $display("FAIL stuck_latency: got %0d want 13", lat); n_bad++; end
    n_cmp++;
    if ({a_pass, a_err, a_fail, a_xz} !== {1'b0, 3'd1, 4'b1000, 3'd0}) begin
      $display("FAIL stuck_result: pass=%b err=%0d fail=%b xz=%0d want 0 1 1000 0",
               a_pass, a_err, a_fail, a_xz); n_bad++;
    end
    cell_mode = 0;
  endtask

  task automatic test_nor_truth();
    int lat;
    repeat (2) tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (b_done) begin lat = c; break; end
      tick();
    end
    n_cmp++;
    if (lat !== 13) begin $display("FAIL nor_latency: got %0d want 13", lat); n_bad++; end
    n_cmp++;
    if ({b_pass, b_err, b_fail} !== {1'b0, 3'd2, 4'b0110}) begin
      $display("FAIL nor_result: pass=%b err=%0d fail=%b want 0 2 0110", b_pass, b_err, b_fail);
      n_bad++;
    end
  endtask

  task automatic test_z_input();
    int lat;
    cell_mode = 2; repeat (2) tick();
    run_a(lat);
    n_cmp++;
    if (lat !== 13) begin $display("FAIL z_latency: got %0d want 13", lat); n_bad++; end
    n_cmp++;
`ifdef XZ_CHECK_EN
    if ({a_pass, a_err, a_fail, a_xz} !== {1'b0, 3'd4, 4'b1111, 3'd4}) begin
      $display("FAIL z_result: pass=%b err=%0d fail=%b xz=%0d want 0 4 1111 4",
               a_pass, a_err, a_fail, a_xz); n_bad++;
    end
`else
    if ({a_pass, a_err, a_fail, a_xz} !== {1'b0, 3'd3, 4'b0111, 3'd0}) begin
      $display("FAIL z_result: pass=%b err=%0d fail=%b xz=%0d want 0 3 0111 0",
               a_pass, a_err, a_fail, a_xz); n_bad++;
    end
`endif
    cell_mode = 0;
  endtask

  task automatic test_restart_ignored();
    int first, ndone;
    logic busy_ok;
    repeat (2) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    first = 0; ndone = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      start_a = (c == 5);
      if (a_done) begin ndone++; if (first == 0) first = c; end
      if (c <= 12 && a_busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    start_a = 1'b0;
    n_cmp++;
    if (first !== 13 || ndone !== 1) begin
      $display("FAIL restart_done: first=%0d count=%0d want 13 1", first, ndone); n_bad++;
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin $display("FAIL restart_busy: got dropped want held"); n_bad++; end
    n_cmp++;
    if (a_pass !== 1'b1) begin $display("FAIL restart_pass: got %b want 1", a_pass); n_bad++; end
  endtask

  task automatic test_mid_rst();
    int lat, ndone;
    repeat (2) tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (6) tick();   // now in cycle k+7
    n_cmp++;
    if (a_busy !== 1'b1) begin $display("FAIL midrst_busy: got %b want 1", a_busy); n_bad++; end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail, a_xz} !== 16'd0) begin
      $display("FAIL midrst_outputs: got %b want all zero",
               {a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fail, a_xz}); n_bad++;
    end
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_done) ndone++;
      tick();
    end
    n_cmp++;
    if (ndone !== 0) begin $display("FAIL midrst_nodone: got %0d pulses want 0", ndone); n_bad++; end
    run_a(lat);
    n_cmp++;
    if (lat !== 13 || {a_pass, a_err, a_fail} !== {1'b1, 3'd0, 4'b0000}) begin
      $display("FAIL midrst_rerun: lat=%0d pass=%b err=%0d fail=%b want 13 1 0 0000",
               lat, a_pass, a_err, a_fail); n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    repeat (2) tick();
    start_a = 1'b1; tick();
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (a_done) begin
        if (d1 == 0) d1 = c;
        else begin d2 = c; start_a = 1'b0; break; end
      end
      tick();
    end
    start_a = 1'b0;
    n_cmp++;
    if (d1 !== 13 || d2 !== 27) begin
      $display("FAIL b2b_done: got %0d,%0d want 13,27", d1, d2); n_bad++;
    end
    repeat (3) tick();
    n_cmp++;
    if (a_busy !== 1'b0) begin $display("FAIL b2b_idle: busy=%b want 0", a_busy); n_bad++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nand_pass();
    test_stuck_at1();
    test_nor_truth();
    test_z_input();
    test_restart_ignored();
    test_mid_rst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
